fifo_uart_tx: RTL and testbench

Serial uplink stage directly downstream of the polling controller's AD FIFO (8-bit, 4096 deep, normal/non-show-ahead read mode). It drains the FIFO one byte at a time and transmits each byte as 8N1 UART, LSB first, on a single `tx` line. It also detects the 0x0D 0x0A frame terminator the polling controller appends after each scan pass, and signals completion of each frame to the host-side logic.

---
 rtl/fifo_uart_tx.sv | 112 +++++++++++
 tb/tb_fifo_uart_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains a normal-mode FIFO one byte at a time and sends each byte as 8N1 UART, LSB first.
// Flags the end of each CR LF terminated frame and keeps a running count of bytes sent.
module fifo_uart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        empty,
    input  logic [7:0]  q,
    output logic        rdreq,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] byte_cnt
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int TW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [2:0] {IDLE, READ, LATCH, START, DATA, STOP} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    cur_byte;
    logic [7:0]    prev_byte;
    logic          bit_end;

    assign bit_end = (timer == TW'(BAUD_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            cur_byte   <= '0;
            prev_byte  <= '0;
            rdreq      <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            byte_cnt   <= '0;
        end else begin
            rdreq      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (enable && !empty) begin
                        state <= READ;
                        rdreq <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                READ: state <= LATCH;
                // q is valid now, one cycle after the read request
                LATCH: begin
                    shift    <= q;
                    cur_byte <= q;
                    timer    <= '0;
                    tx       <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (bit_end) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer      <= '0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                        byte_cnt   <= byte_cnt + 1'b1;
                        prev_byte  <= cur_byte;
                        frame_done <= (cur_byte == 8'h0A) && (prev_byte == 8'h0D);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a queue-backed FIFO model feeds the DUT and
// a bit-centre sampler decodes the line; a shortened baud divider keeps runs short.
module tb_fifo_uart_tx;
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 1_000_000;
    localparam int BD       = 50;          // 50e6 / 1e6
    localparam int PERIOD   = 10 * BD + 3; // byte-to-byte spacing
    localparam int TMO      = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        empty = 1'b1;
    logic [7:0]  q = 8'h00;
    logic        rdreq, tx, busy, frame_done;
    logic [15:0] byte_cnt;

    fifo_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .reset(reset), .enable(enable), .empty(empty), .q(q),
        .rdreq(rdreq), .tx(tx), .busy(busy), .frame_done(frame_done), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo[$];
    int cyc = 0;
    int rd_cnt = 0, fd_cnt = 0, fd_busy = 0, txlow_cnt = 0, busy_cnt = 0;
    int n_chk = 0, n_fail = 0;

    // Normal-mode FIFO: data appears on q the cycle after rdreq
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rdreq && fifo.size() > 0) q <= fifo.pop_front();
    end

    always @(negedge clk) begin
        empty <= (fifo.size() == 0);
        if (rdreq) rd_cnt <= rd_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (frame_done && busy) fd_busy <= fd_busy + 1;
        if (!tx) txlow_cnt <= txlow_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        fifo.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Waits for a start bit, samples every bit centre, optionally drops enable in bit 3.
    task automatic rx_byte(output logic [7:0] b, output int t0, input bit drop3);
        int n;
        n  = 0;
        b  = 8'h00;
        t0 = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < TMO);
        chk("start_edge", {31'd0, tx}, 32'd0);
        if (tx !== 1'b0) return;
        t0 = cyc;
        repeat (BD / 2) @(negedge clk);
        chk("start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (BD) @(negedge clk);
            b[i] = tx;
            if (drop3 && i == 3) enable = 1'b0;
        end
        repeat (BD) @(negedge clk);
        chk("stop_bit", {31'd0, tx}, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] bytes[5], output int fd0);
        logic [7:0] b;
        int t0, tprev, rd0;
        fd0 = fd_cnt;
        rd0 = rd_cnt;
        foreach (bytes[i]) fifo.push_back(bytes[i]);
        @(negedge clk);
        enable = 1'b1;
        tprev = 0;
        for (int i = 0; i < 5; i++) begin
            rx_byte(b, t0, 1'b0);
            chk($sformatf("frame_byte%0d", i), {24'd0, b}, {24'd0, bytes[i]});
            if (i > 0) chk($sformatf("frame_gap%0d", i), t0 - tprev, PERIOD);
            tprev = t0;
        end
        repeat (BD) @(negedge clk);
        enable = 1'b0;
        chk("frame_rdreq", rd_cnt - rd0, 5);
        chk("frame_cnt", {16'd0, byte_cnt}, 5);
    endtask

    initial begin
        logic [7:0] b;
        int t0, ten, fd0, rd0, tl0, bz0;
        logic [7:0] frame_a[5] = '{8'h80, 8'h3F, 8'hCC, 8'h0D, 8'h0A};
        logic [7:0] frame_b[5] = '{8'h0A, 8'h41, 8'h0D, 8'h41, 8'h0A};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx",    {31'd0, tx},         32'd1);
        chk("rst_rdreq", {31'd0, rdreq},      32'd0);
        chk("rst_busy",  {31'd0, busy},       32'd0);
        chk("rst_fd",    {31'd0, frame_done}, 32'd0);
        chk("rst_cnt",   {16'd0, byte_cnt},   32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single byte 0x55
        fifo.push_back(8'h55);
        @(negedge clk);
        rd0 = rd_cnt;
        enable = 1'b1;
        ten = cyc;
        rx_byte(b, t0, 1'b0);
        chk("single_lat", t0 - ten, 3);
        chk("single_byte", {24'd0, b}, 32'h55);
        repeat (BD / 2 + 2) @(negedge clk);
        chk("single_rdreq", rd_cnt - rd0, 1);
        chk("single_cnt", {16'd0, byte_cnt}, 1);
        chk("single_busy", {31'd0, busy}, 0);
        enable = 1'b0;

        // Frame with CR LF terminator
        do_reset();
        send_frame(frame_a, fd0);
        chk("frame_fd", fd_cnt - fd0, 1);
        chk("frame_fd_busy", fd_busy, 0);

        // Lone terminator bytes
        do_reset();
        send_frame(frame_b, fd0);
        chk("lone_fd", fd_cnt - fd0, 0);

        // Empty with enable, then data with enable low
        do_reset();
        rd0 = rd_cnt; tl0 = txlow_cnt; bz0 = busy_cnt;
        enable = 1'b1;
        repeat (10000) @(negedge clk);
        chk("empty_rdreq", rd_cnt - rd0, 0);
        chk("empty_txlow", txlow_cnt - tl0, 0);
        chk("empty_busy", busy_cnt - bz0, 0);
        enable = 1'b0;
        fifo.push_back(8'hA5);
        rd0 = rd_cnt; tl0 = txlow_cnt; bz0 = busy_cnt;
        repeat (10000) @(negedge clk);
        chk("dis_rdreq", rd_cnt - rd0, 0);
        chk("dis_txlow", txlow_cnt - tl0, 0);
        chk("dis_busy", busy_cnt - bz0, 0);

        // Enable dropped during bit 3 of the first of two bytes
        do_reset();
        fifo.push_back(8'h3C);
        fifo.push_back(8'hA5);
        @(negedge clk);
        rd0 = rd_cnt;
        enable = 1'b1;
        rx_byte(b, t0, 1'b1);
        chk("drop_byte0", {24'd0, b}, 32'h3C);
        repeat (3 * BD) @(negedge clk);
        chk("drop_rdreq", rd_cnt - rd0, 1);
        chk("drop_busy", {31'd0, busy}, 0);
        chk("drop_cnt", {16'd0, byte_cnt}, 1);
        enable = 1'b1;
        rx_byte(b, t0, 1'b0);
        chk("drop_byte1", {24'd0, b}, 32'hA5);
        repeat (BD) @(negedge clk);
        chk("drop_rdreq2", rd_cnt - rd0, 2);
        chk("drop_cnt2", {16'd0, byte_cnt}, 2);
        enable = 1'b0;

        // Reset during data bit 5 (byte_cnt is 2 going in)
        fifo.push_back(8'h96);
        fifo.push_back(8'h69);
        @(negedge clk);
        enable = 1'b1;
        t0 = 0;
        while (tx !== 1'b0 && t0 < TMO) begin
            @(negedge clk);
            t0++;
        end
        repeat (6 * BD + BD / 2) @(negedge clk);
        chk("mid_busy_pre", {31'd0, busy}, 1);
        reset = 1'b1;
        #1;
        chk("mid_tx",   {31'd0, tx},       1);
        chk("mid_busy", {31'd0, busy},     0);
        chk("mid_cnt",  {16'd0, byte_cnt}, 0);
        @(negedge clk);
        reset = 1'b0;
        rx_byte(b, t0, 1'b0);
        chk("mid_next_byte", {24'd0, b}, 32'h69);
        repeat (BD) @(negedge clk);
        chk("mid_cnt_after", {16'd0, byte_cnt}, 1);
        enable = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
